// File: rtl/mem_col_pkg.sv
// Shared types and default sizing for the column read sequencer.
package mem_col_pkg;

    localparam int unsigned NUM_ELEM_DEF   = 1024;
    localparam int unsigned ELEM_WIDTH_DEF = 1;
    localparam int unsigned PACK_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } mem_col_seq_state_e;

endpackage

// File: rtl/mem_col_ptr_wrap.sv
// Loadable column pointer that counts modulo NUM_ELEM when enabled.
module mem_col_ptr_wrap
    import mem_col_pkg::*;
#(
    parameter int unsigned NUM_ELEM = NUM_ELEM_DEF,
    localparam int unsigned AW      = $clog2(NUM_ELEM)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    localparam logic [AW-1:0] LastCol = AW'(NUM_ELEM - 1);

    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_next;

    // Next pointer: load has priority over increment; wrap after the last column.
    always_comb begin
        w_ptr_next = r_ptr;
        if (load_i) begin
            w_ptr_next = load_val_i;
        end else if (inc_i) begin
            w_ptr_next = (r_ptr == LastCol) ? '0 : r_ptr + 1'b1;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/mux1024to1.sv
// Combinational 1024:1 single-bit column mux.
module mux1024to1 (
    input  logic [1023:0] i_i,
    input  logic [9:0]    sel_i,
    output logic          o_o
);

    assign o_o = i_i[sel_i];

endmodule

// File: rtl/mem_col_read_seq.sv
// Burst read sequencer: walks the column mux select and packs samples into stream words.
module mem_col_read_seq
    import mem_col_pkg::*;
#(
    parameter int unsigned NUM_ELEM   = NUM_ELEM_DEF,
    parameter int unsigned ELEM_WIDTH = ELEM_WIDTH_DEF,
    parameter int unsigned PACK       = PACK_DEF,
    localparam int unsigned AW        = $clog2(NUM_ELEM),
    localparam int unsigned LW        = $clog2(NUM_ELEM) + 1,
    localparam int unsigned DW        = PACK * ELEM_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [LW-1:0]         req_len_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic [AW-1:0]         sel_o,
    input  logic [ELEM_WIDTH-1:0] mux_data_i,
    output logic [DW-1:0]         data_o,
    output logic                  data_last_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  busy_o
);

    // Slot counter needs at least one bit even when PACK is 1.
    localparam int unsigned SW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [SW-1:0] LastSlot = SW'(PACK - 1);
    localparam logic [LW-1:0] OneLeft  = LW'(1);

    mem_col_seq_state_e r_state, w_state_next;
    logic [LW-1:0] r_rem, w_rem_next;
    logic [SW-1:0] r_slot, w_slot_next;
    logic [DW-1:0] r_pack, w_pack_next;
    logic [DW-1:0] r_data, w_data_next;
    logic          r_last, w_last_next;

    logic          w_load;
    logic          w_step;
    logic          w_word_done;
    logic [DW-1:0] w_pack_merged;
    logic [AW-1:0] w_sel;

    // Zero-length requests are consumed in IDLE without starting a burst.
    assign w_load      = (r_state == IDLE) && req_valid_i && (req_len_i != '0);
    assign w_step      = (r_state == SCAN);
    assign w_word_done = w_step && ((r_slot == LastSlot) || (r_rem == OneLeft));

    // Pack register with the current mux sample dropped into its slot.
    always_comb begin
        w_pack_merged = r_pack;
        w_pack_merged[r_slot*ELEM_WIDTH +: ELEM_WIDTH] = mux_data_i;
    end

    // Next-state and datapath updates for the IDLE/SCAN/DRAIN controller.
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_slot_next  = r_slot;
        w_pack_next  = r_pack;
        w_data_next  = r_data;
        w_last_next  = r_last;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_next = SCAN;
                    w_rem_next   = req_len_i;
                    w_slot_next  = '0;
                    w_pack_next  = '0;
                end
            end
            SCAN: begin
                w_rem_next = r_rem - 1'b1;
                if (w_word_done) begin
                    // Clearing pack here keeps unfilled slots of a short final word at zero.
                    w_slot_next  = '0;
                    w_pack_next  = '0;
                    w_data_next  = w_pack_merged;
                    w_last_next  = (r_rem == OneLeft);
                    w_state_next = DRAIN;
                end else begin
                    w_slot_next = r_slot + 1'b1;
                    w_pack_next = w_pack_merged;
                end
            end
            DRAIN: begin
                if (data_ready_i) begin
                    w_state_next = r_last ? IDLE : SCAN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_slot  <= '0;
            r_pack  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_slot  <= w_slot_next;
            r_pack  <= w_pack_next;
            r_data  <= w_data_next;
            r_last  <= w_last_next;
        end
    end

    // Column pointer advances only while scanning, so it freezes through DRAIN.
    mem_col_ptr_wrap #(
        .NUM_ELEM (NUM_ELEM)
    ) u_ptr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (w_load),
        .load_val_i (req_addr_i),
        .inc_i      (w_step),
        .ptr_o      (w_sel)
    );

    assign sel_o        = w_sel;
    assign req_ready_o  = (r_state == IDLE);
    assign data_valid_o = (r_state == DRAIN);
    assign busy_o       = (r_state != IDLE);
    assign data_o       = r_data;
    assign data_last_o  = r_last;

endmodule

// File: tb/tb_mem_col_read_seq.sv
// Self-checking bench for mem_col_read_seq driven through a 1024:1 column mux.
module tb_mem_col_read_seq;

    localparam int N    = 1024;
    localparam int PACK = 8;

    logic          clk;
    logic          rst_n;
    logic [9:0]    req_addr;
    logic [10:0]   req_len;
    logic          req_valid;
    logic          req_ready;
    logic [9:0]    sel;
    logic          mux_data;
    logic [7:0]    data;
    logic          data_last;
    logic          data_valid;
    logic          data_ready;
    logic          busy;
    logic [N-1:0]  img;

    int n_checks = 0;
    int n_fail   = 0;

    mem_col_read_seq dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .sel_o        (sel),
        .mux_data_i   (mux_data),
        .data_o       (data),
        .data_last_o  (data_last),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .busy_o       (busy)
    );

    mux1024to1 u_mux (
        .i_i   (img),
        .sel_i (sel),
        .o_o   (mux_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready_o"},  32'(req_ready),  32'd1);
        check({tag, " sel_o"},        32'(sel),        32'd0);
        check({tag, " data_o"},       32'(data),       32'd0);
        check({tag, " data_last_o"},  32'(data_last),  32'd0);
        check({tag, " data_valid_o"}, 32'(data_valid), 32'd0);
        check({tag, " busy_o"},       32'(busy),       32'd0);
    endtask

    // Mode 0: ready always high; 1: random ready; 2: ready low for the first 5 valid cycles.
    task automatic run_burst(input int addr, input int len, input int mode,
                             output int nwords, output logic [7:0] w0);
        logic [7:0] exp_w[$];
        logic       exp_l[$];
        int         sel_q[$];
        int         first_valid;
        int         bp_left;
        int         budget;
        int         nbad;
        bit         done;
        logic       rdy;
        logic       prev_v, prev_r, prev_l;
        logic [7:0] prev_d;
        logic [9:0] prev_s;

        // Reference: words are consecutive PACK-element chunks of the wrapped column walk.
        for (int w = 0; w * PACK < len; w++) begin
            logic [7:0] word;
            word = '0;
            for (int j = 0; j < PACK; j++) begin
                if (w * PACK + j < len) word[j] = img[(addr + w * PACK + j) % N];
            end
            exp_w.push_back(word);
            exp_l.push_back((w + 1) * PACK >= len);
        end

        nwords = 0;
        w0 = '0;
        first_valid = -1;
        bp_left = 5;
        done = 1'b0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_l = 1'b0;
        prev_d = '0;
        prev_s = '0;
        budget = 3 * len + 20 * (len / PACK + 1) + 50;

        @(negedge clk);
        req_addr  = 10'(addr);
        req_len   = 11'(len);
        req_valid = 1'b1;
        data_ready = (mode != 2);
        check("req_ready_o before request", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;

        for (int c = 1; c <= budget && !done; c++) begin
            if (c > 1) @(negedge clk);
            if (busy && !data_valid) sel_q.push_back(int'(sel));
            if (prev_v && !prev_r) begin
                check("hold under backpressure (valid,data,sel,last)",
                      {11'd0, data_valid, data, sel, data_last, 1'b0},
                      {11'd0, 1'b1, prev_d, prev_s, prev_l, 1'b0});
            end
            if (data_valid && first_valid < 0) first_valid = c;
            case (mode)
                1: rdy = 1'($urandom_range(0, 1));
                2: begin
                    if (data_valid && bp_left > 0) begin
                        rdy = 1'b0;
                        bp_left--;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = 1'b1;
            endcase
            data_ready = rdy;
            if (data_valid && rdy) begin
                if (nwords < exp_w.size()) begin
                    check("data_o word", 32'(data), 32'(exp_w[nwords]));
                    check("data_last_o word", 32'(data_last), 32'(exp_l[nwords]));
                end else begin
                    check("unexpected extra word", 32'(nwords), 32'(exp_w.size()));
                end
                if (nwords == 0) w0 = data;
                nwords++;
                if (data_last) begin
                    check("req_ready_o during last handshake", 32'(req_ready), 32'd0);
                    @(negedge clk);
                    check("req_ready_o after last handshake", 32'(req_ready), 32'd1);
                    check("busy_o after last handshake", 32'(busy), 32'd0);
                    done = 1'b1;
                end
            end
            prev_v = data_valid;
            prev_r = rdy;
            prev_d = data;
            prev_s = sel;
            prev_l = data_last;
        end
        data_ready = 1'b1;

        check("burst completed within cycle budget", 32'(done), 32'd1);
        check("word count", 32'(nwords), 32'(exp_w.size()));
        if (mode == 0 && len >= PACK) begin
            check("first data_valid_o cycle after accept", 32'(first_valid), 32'(PACK + 1));
        end
        nbad = 0;
        for (int k = 0; k < sel_q.size(); k++) begin
            if (sel_q[k] != (addr + k) % N) begin
                if (nbad == 0) begin
                    $display("FAIL sel_o step %0d: got %0d, required %0d",
                             k, sel_q[k], (addr + k) % N);
                end
                nbad++;
            end
        end
        check("sel_o scan cycle count", 32'(sel_q.size()), 32'(len));
        check("sel_o sequence mismatches", 32'(nbad), 32'd0);
    endtask

    typedef struct {
        int         addr;
        int         len;
        int         mode;
        int         base;
        logic [7:0] pat;
        logic [7:0] exp_w0;
        int         exp_nw;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         nw;
        logic [7:0] w0;

        rst_n      = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_valid  = 1'b0;
        data_ready = 1'b1;
        for (int i = 0; i < N / 32; i++) img[i*32 +: 32] = $urandom;

        vecs[0] = '{addr: 0,    len: 8,    mode: 0, base: 0,    pat: 8'hA5, exp_w0: 8'hA5, exp_nw: 1};
        vecs[1] = '{addr: 1020, len: 8,    mode: 0, base: 1020, pat: 8'h3C, exp_w0: 8'h3C, exp_nw: 1};
        vecs[2] = '{addr: 5,    len: 3,    mode: 0, base: 5,    pat: 8'hFF, exp_w0: 8'h07, exp_nw: 1};
        vecs[3] = '{addr: 64,   len: 16,   mode: 2, base: 64,   pat: 8'h96, exp_w0: 8'h96, exp_nw: 2};
        vecs[4] = '{addr: 1000, len: 1030, mode: 0, base: 1000, pat: 8'h5A, exp_w0: 8'h5A, exp_nw: 129};
        vecs[5] = '{addr: 1023, len: 9,    mode: 1, base: 1023, pat: 8'hC3, exp_w0: 8'hC3, exp_nw: 2};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < 8; j++) img[(vecs[v].base + j) % N] = vecs[v].pat[j];
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].mode, nw, w0);
            check("table first word", 32'(w0), 32'(vecs[v].exp_w0));
            check("table word count", 32'(nw), 32'(vecs[v].exp_nw));
        end

        // Zero-length request: accepted, nothing produced.
        @(negedge clk);
        req_addr  = 10'd77;
        req_len   = '0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("len0 data_valid_o", 32'(data_valid), 32'd0);
            check("len0 req_ready_o", 32'(req_ready), 32'd1);
            check("len0 busy_o", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Reset mid-SCAN of a 16-element burst.
        req_addr  = 10'd200;
        req_len   = 11'd16;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_o mid-scan before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-burst reset");
        rst_n = 1'b1;
        run_burst(300, 16, 0, nw, w0);

        // Randomized bursts against the reference model.
        for (int r = 0; r < 25; r++) begin
            run_burst(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 40)),
                      int'($urandom_range(0, 1)), nw, w0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
